// File: rtl/counter_mod_updown.sv
// Modulo-MODULUS up/down counter with saturating parallel load, a Gray-coded view
// of the count, a terminal-count strobe and a sticky wrap flag.
module counter_mod_updown #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_nxt;
    logic             ovf_nxt;

    // tc is gated by reset so it reads 0 while count is being forced to zero.
    assign tc   = ~reset & en & ~load &
                  ((up & (count == MAX)) | (~up & (count == '0)));
    assign gray = count ^ (count >> 1);

    always_comb begin
        count_nxt = count;
        if (load) begin
            // load_val <= MAX is the same as load_val < MODULUS, without a width mix.
            count_nxt = (load_val > MAX) ? MAX : load_val;
        end else if (en) begin
            if (up) begin
                count_nxt = (count == MAX) ? '0 : count + ONE;
            end else begin
                count_nxt = (count == '0) ? MAX : count - ONE;
            end
        end
    end

    always_comb begin
        ovf_nxt = ovf;
        if (tc) begin
            ovf_nxt = 1'b1;
        end else if (clr_ovf) begin
            ovf_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench for counter_mod_updown (WIDTH=4, MODULUS=10): directed vector table,
// constrained-random run against a small model, and an asynchronous reset sequence.
module tb_counter_mod_updown;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, up, load, clr_ovf;
    logic [3:0] load_val;
    logic [3:0] count, gray;
    logic       tc, ovf;

    int n_cmp = 0;
    int n_err = 0;

    // expected {ovf, count} after the next rising edge
    logic [4:0] exp_q[$];

    logic [3:0] gray_tab [10] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13};

    typedef struct {
        logic       en, up, load;
        logic [3:0] lv;
        logic       clr;
        logic [3:0] ec;
        logic       etc, eo;
    } vec_t;
    vec_t vt[$];

    counter_mod_updown #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .count(count), .gray(gray), .tc(tc), .ovf(ovf)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic u, input logic l, input logic [3:0] lv,
                       input logic c, input logic [3:0] ec, input logic etc, input logic eo);
        vec_t v;
        v.en = e; v.up = u; v.load = l; v.lv = lv; v.clr = c;
        v.ec = ec; v.etc = etc; v.eo = eo;
        vt.push_back(v);
    endtask

    // Drive one cycle of inputs at the falling edge, check the pre-edge tc and
    // queue the post-edge expectation for the monitor.
    task automatic step(input logic e, input logic u, input logic l, input logic [3:0] lv,
                        input logic c, input logic [3:0] ec, input logic etc, input logic eo);
        @(negedge clk);
        en = e; up = u; load = l; load_val = lv; clr_ovf = c;
        #1;
        chk("tc", 8'(tc), 8'(etc));
        exp_q.push_back({eo, ec});
    endtask

    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("count", 8'(count), 8'(e[3:0]));
            chk("ovf", 8'(ovf), 8'(e[4]));
            chk("gray", 8'(gray), 8'(gray_tab[e[3:0]]));
        end
    end

    initial begin
        int mc, mo, mtc;
        logic r_en, r_up, r_ld, r_clr;
        logic [3:0] r_lv;

        // directed table, starting from count=0, ovf=0
        for (int i = 1; i <= 12; i++) add(1, 1, 0, 0, 0, 4'(i % 10), i == 10, i >= 10);
        add(0, 1, 0, 0,  1, 2, 0, 0);
        add(1, 0, 1, 0,  0, 0, 0, 0);
        add(1, 0, 0, 0,  0, 9, 1, 1);
        add(1, 1, 1, 7,  0, 7, 0, 1);
        add(1, 1, 1, 12, 0, 9, 0, 1);
        add(1, 1, 0, 0,  1, 0, 1, 1);
        add(0, 1, 0, 0,  1, 0, 0, 0);
        add(0, 1, 1, 4,  0, 4, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1'(i % 2), 0, 0, 0, 4, 0, 0);
        add(1, 0, 0, 0,  0, 3, 0, 0);
        add(1, 0, 0, 0,  0, 2, 0, 0);
        add(1, 1, 0, 0,  0, 3, 0, 0);
        add(0, 0, 1, 9,  0, 9, 0, 0);
        add(0, 0, 1, 10, 0, 9, 0, 0);
        add(1, 0, 1, 15, 0, 9, 0, 0);
        add(1, 1, 0, 0,  0, 0, 1, 1);
        add(0, 0, 1, 3,  0, 3, 0, 1);
        add(1, 0, 0, 0,  0, 2, 0, 1);

        // reset state, checked before any clock edge
        reset = 1'b1; en = 1'b1; up = 1'b0; load = 1'b0; load_val = 4'd0; clr_ovf = 1'b0;
        #1;
        chk("rst_count", 8'(count), 8'd0);
        chk("rst_ovf", 8'(ovf), 8'd0);
        chk("rst_gray", 8'(gray), 8'd0);
        chk("rst_tc", 8'(tc), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; en = 1'b0;

        foreach (vt[i]) step(vt[i].en, vt[i].up, vt[i].load, vt[i].lv, vt[i].clr,
                             vt[i].ec, vt[i].etc, vt[i].eo);

        // random run against a modulo-arithmetic model
        mc = 2; mo = 1;
        for (int i = 0; i < 60; i++) begin
            r_en = 1'($urandom_range(0, 3) != 0);
            r_up = 1'($urandom_range(0, 1));
            r_ld = 1'($urandom_range(0, 7) == 0);
            r_lv = 4'($urandom_range(0, 15));
            r_clr = 1'($urandom_range(0, 3) == 0);
            mtc = 0;
            if (r_ld) begin
                mc = (r_lv > 9) ? 9 : int'(r_lv);
            end else if (r_en) begin
                mtc = r_up ? int'(mc == 9) : int'(mc == 0);
                mc = r_up ? (mc + 1) % 10 : (mc + 9) % 10;
            end
            if (mtc != 0) mo = 1;
            else if (r_clr) mo = 0;
            step(r_en, r_up, r_ld, r_lv, r_clr, 4'(mc), 1'(mtc), 1'(mo));
        end

        // asynchronous reset mid-count with a pending load and a would-be tc
        step(0, 0, 1, 0, 0, 0, 0, 1'(mo));
        step(1, 0, 0, 0, 0, 9, 1, 1);
        step(0, 0, 1, 5, 0, 5, 0, 1);
        @(posedge clk);
        #5;
        reset = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; up = 1'b0;
        #1;
        chk("async_count", 8'(count), 8'd0);
        chk("async_ovf", 8'(ovf), 8'd0);
        chk("async_gray", 8'(gray), 8'd0);
        chk("async_tc", 8'(tc), 8'd0);
        @(posedge clk);
        #1;
        chk("held_rst_count", 8'(count), 8'd0);
        @(negedge clk);
        reset = 1'b0; load = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_hold", 8'(count), 8'd0);
        step(1, 1, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        chk("drain_q", 8'(exp_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
